// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// registered slices, with a valid/ready handshake that stalls the whole pipe.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             cy_q  [STAGES];
    logic             cmsb_q;

    logic             vld_src [STAGES];
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic [WIDTH-1:0] s_src   [STAGES];
    logic             cy_src  [STAGES];
    logic [C:0]       slice   [STAGES];
    logic [WIDTH-1:0] s_nxt   [STAGES];
    logic             cmsb_nxt;
    logic             advance;

    assign out_valid = vld_q[STAGES-1];
    assign advance   = out_ready || !out_valid;
    assign in_ready  = advance;

    always_comb begin
        vld_src[0] = in_valid;
        a_src[0]   = a;
        b_src[0]   = sub ? ~b : b;
        s_src[0]   = '0;
        cy_src[0]  = sub ? ~c_in : c_in;
        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
            cy_src[k]  = cy_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_src[k][k*C +: C]} + {1'b0, b_src[k][k*C +: C]}
                     + {{C{1'b0}}, cy_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*C +: C] = slice[k][C-1:0];
        end
        // carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
        cmsb_nxt = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
                 ^ slice[STAGES-1][C-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                cy_q[k]  <= 1'b0;
            end
            cmsb_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_src[k];
                a_q[k]   <= a_src[k];
                b_q[k]   <= b_src[k];
                s_q[k]   <= s_nxt[k];
                cy_q[k]  <= slice[k][C];
            end
            cmsb_q <= cmsb_nxt;
        end
    end

    assign sum   = s_q[STAGES-1];
    assign c_out = cy_q[STAGES-1];
    assign ovf   = cy_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed cases, a stalled mixed stream,
// random traffic against an arithmetic reference model, and async reset.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, c_in = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, c_out, ovf;

    logic        in_valid2 = 1'b0, in_ready2, c_in2 = 1'b0, sub2 = 1'b0;
    logic [3:0]  a2 = '0, b2 = '0, sum2;
    logic        out_valid2, out_ready2 = 1'b1, c_out2, ovf2;

    int total = 0;
    int bad = 0;
    logic [17:0] sbq [$];
    int retired = 0;
    logic        held = 1'b0;
    logic [17:0] held_val = '0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipe_addsub #(.WIDTH(4), .STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .c_out(c_out2), .ovf(ovf2)
    );

    // Reference: integer arithmetic; returns {c_out, ovf, sum}
    function automatic logic [17:0] model(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci,
                                          input logic sb);
        longint ua = longint'(x);
        longint ub = longint'(y);
        longint cl = ci ? 64'sd1 : 64'sd0;
        longint full = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint t, sa, sbv, s, m;
        logic [63:0] mv;
        logic co, ov;
        t  = sb ? (ua - ub - cl) : (ua + ub + cl);
        co = sb ? (t >= 0) : (t >= full);
        m  = ((t % full) + full) % full;
        sa  = (ua >= half) ? ua - full : ua;
        sbv = (ub >= half) ? ub - full : ub;
        s  = sb ? (sa - sbv - cl) : (sa + sbv + cl);
        ov = (s > half - 1) || (s < -half);
        mv = 64'(m);
        return {co, ov, mv[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of DUT1 traffic: retire/stall checks, capture, advance to next negedge
    task automatic tick();
        logic [17:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", {out_valid, 15'd0, sum}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_sum", {16'd0, sum}, {16'd0, e[15:0]});
                chk("sb_cout", {31'd0, c_out}, {31'd0, e[17]});
                chk("sb_ovf", {31'd0, ovf}, {31'd0, e[16]});
                retired++;
            end
            held = 1'b0;
        end else if (out_valid && !out_ready) begin
            if (held) chk("stall_hold", {14'd0, c_out, ovf, sum}, {14'd0, held_val});
            held = 1'b1;
            held_val = {c_out, ovf, sum};
        end else begin
            held = 1'b0;
        end
        if (in_valid && in_ready) sbq.push_back(model(16, a, b, c_in, sub));
        @(negedge clk);
    endtask

    task automatic one_beat(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
        int n;
        a = xa; b = xb; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        tick();
    endtask

    initial begin
        int n, c, idx;
        logic acc, saw_block;
        logic [17:0] e2;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout_ovf", {30'd0, c_out, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // directed single beats
        one_beat("add3p4", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        one_beat("carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_beat("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_beat("sub_borrow", 16'h000A, 16'h000F, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0);
        one_beat("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        one_beat("sub_bin", 16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

        // 8-beat mixed stream, consumer stalled for cycles 5..9
        idx = 0; saw_block = 1'b0; retired = 0;
        for (c = 0; c < 60 && (idx < 8 || sbq.size() != 0); c++) begin
            if (idx < 8 && !(in_valid && !in_ready)) begin
                a = 16'($urandom); b = 16'($urandom);
                c_in = 1'($urandom); sub = idx[0];
            end
            in_valid = (idx < 8);
            out_ready = !(c >= 5 && c <= 9);
            #1;
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_block = 1'b1;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_in_ready_dropped", {31'd0, saw_block}, 32'd1);
        chk("stream_count", retired, 8);
        chk("stream_drained", sbq.size(), 0);

        // random traffic with random backpressure
        idx = 0; retired = 0;
        for (c = 0; c < 400 && (idx < 40 || sbq.size() != 0); c++) begin
            if (!(in_valid && !in_ready)) begin
                a = 16'($urandom); b = 16'($urandom);
                c_in = 1'($urandom); sub = 1'($urandom);
                in_valid = (idx < 40) && ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("rand_count", retired, idx);
        chk("rand_drained", sbq.size(), 0);

        // narrow instance: WIDTH=4, STAGES=2
        a2 = 4'd9; b2 = 4'd9; c_in2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
        e2 = model(4, 16'd9, 16'd9, 1'b0, 1'b0);
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 1;
        while (!out_valid2 && n < 20) begin @(negedge clk); n++; end
        chk("w4_lat", n, 2);
        chk("w4_sum", {28'd0, sum2}, 32'd2);
        chk("w4_cout_ovf", {30'd0, c_out2, ovf2}, 32'd3);
        chk("w4_model", {14'd0, c_out2, ovf2, 12'd0, sum2}, {14'd0, e2});
        a2 = 4'd10; b2 = 4'd5; c_in2 = 1'b1; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        @(negedge clk);
        #1;
        chk("w4b_valid", {31'd0, out_valid2}, 32'd1);
        chk("w4b_sum", {28'd0, sum2}, 32'd0);
        chk("w4b_cout_ovf", {30'd0, c_out2, ovf2}, 32'd2);
        @(negedge clk);

        // async reset with 3 beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); c_in = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        sbq.delete();
        held = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) n++;
            @(negedge clk);
        end
        chk("post_rst_no_stale", n, 0);
        one_beat("post_rst", 16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0234, 1'b1, 1'b0);
        chk("final_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
Parametrised, pipelined N-bit adder/subtractor for the Basys3 arithmetic blocks. It extends the 4-bit ripple full adder to arbitrary width, adds a subtract mode and signed-overflow detection, and splits the carry chain into STAGES registered slices. Operands and results move through a valid/ready handshake with whole-pipeline stall. It sits between operand sources (switch capture, ALU control) and result consumers (display, accumulators).

Parameters:
WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and number of carry-chain slices; slice width C = WIDTH/STAGES; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat present.
in_ready  output  1  pipeline accepts a beat this cycle.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
c_in  input  1  carry-in in add mode; borrow-in in subtract mode.
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat present.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
c_out  output  1  carry-out in add mode; in subtract mode 1 = no borrow.
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, sum = 0, c_out = 0, ovf = 0. Data registers are cleared. in_ready = 1 from the first cycle after reset.
- Arithmetic: add computes {c_out,sum} = a + b + c_in. Subtract computes {c_out,sum} = a + ~b + (1 - c_in), so sum = a - b - c_in mod 2^WIDTH. ovf = carry into MSB XOR carry out of MSB, in both modes.
- Transform at capture: b_eff = sub ? ~b : b; cin_eff = sub ? ~c_in : c_in.
- Pipeline: stage k (k = 0..STAGES-1) adds bits [k*C +: C] of a and b_eff with the carry registered by stage k-1 (cin_eff for stage 0).
  - Each stage registers its result slice, its carry, and all lower slices already computed.
  - Upper operand slices are delayed alongside.
  - The last stage also registers the carry into the MSB for ovf.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, with no stall. Throughput is 1 beat per cycle.
- Handshake:
  - advance = out_ready || !out_valid; in_ready = advance (combinational).
  - When advance = 1, every stage shifts one position. Stage 0 loads in_valid, and bubbles propagate as invalid entries.
  - When advance = 0, all stages hold. sum, c_out, ovf and out_valid stay stable while out_valid && !out_ready.
  - Inputs offered while in_ready = 0 are not captured; the source must hold them.
- Simultaneous events: with the pipe full, out_ready = 1 and in_valid = 1, the output beat retires and the new beat enters in the same edge; there is no bubble.
- Mode is per beat: sub/c_in are captured with the operands, so mixed add/sub streams are legal back-to-back.
- STAGES = 1: degenerates to a single registered adder with latency 1.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. The first beat after reset release appears after STAGES cycles.
- Data registers of invalid stages may hold any value. sum/c_out/ovf are only meaningful when out_valid = 1, except the reset values above.

Test Plan:
- Default params, out_ready = 1, one beat: a=0x0003, b=0x0004, c_in=0, sub=0 -> after exactly 4 cycles out_valid=1, sum=0x0007, c_out=0, ovf=0.
- Carry across every slice boundary: a=0xFFFF, b=0x0000, c_in=1, sub=0 -> sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
- Subtract and borrow: a=0x000A, b=0x000F, sub=1, c_in=0 -> sum=0xFFFB, c_out=0. Then a=0x8000, b=0x0001, sub=1, c_in=0 -> sum=0x7FFF, c_out=1, ovf=1. Then a=0x0005, b=0x0002, sub=1, c_in=1 -> sum=0x0002, c_out=1.
- Back-to-back stream of 8 mixed add/sub beats with out_ready held 0 for cycles 5-9:
  - in_ready drops while the pipe is full.
  - Outputs hold stable during the stall.
  - All 8 results emerge in order, matching the reference model, with none lost or duplicated.
- WIDTH=4, STAGES=2: a=9, b=9, c_in=0 -> sum=2, c_out=1, ovf=1 at latency 2. Then a=10, b=5, c_in=1 -> sum=0, c_out=1, ovf=0.
- Assert rst_n low asynchronously mid-clock with 3 beats in flight:
  - out_valid falls immediately and sum=0.
  - After release, no stale beat appears.
  - A new beat emerges at latency STAGES.
